// File: rtl/multi_channel_initiator.sv
// Two-channel valid/ready initiator: each channel queues pushed words in a FIFO,
// presents the head until accepted, and flags a responder that stalls too long.
module multi_channel_initiator #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_push,
    input  logic [DATA_W-1:0]        m_push_data,
    output logic                     m_full,
    output logic [$clog2(DEPTH):0]   m_count,
    output logic                     m_timeout,
    output logic                     master_valid,
    input  logic                     master_ready,
    output logic [DATA_W-1:0]        master_data,
    input  logic                     s_push,
    input  logic [DATA_W-1:0]        s_push_data,
    output logic                     s_full,
    output logic [$clog2(DEPTH):0]   s_count,
    output logic                     s_timeout,
    output logic                     slave_valid,
    input  logic                     slave_ready,
    output logic [DATA_W-1:0]        slave_data,
    input  logic                     clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    // Index 0 is the master channel, index 1 the slave channel.
    logic              push_v      [2];
    logic [DATA_W-1:0] push_data_v [2];
    logic              ready_v     [2];
    logic              valid_v     [2];
    logic              full_v      [2];
    logic              timeout_v   [2];
    logic [CW-1:0]     count_v     [2];
    logic [DATA_W-1:0] data_v      [2];

    assign push_v[0]      = m_push;
    assign push_v[1]      = s_push;
    assign push_data_v[0] = m_push_data;
    assign push_data_v[1] = s_push_data;
    assign ready_v[0]     = master_ready;
    assign ready_v[1]     = slave_ready;

    assign m_full       = full_v[0];
    assign m_count      = count_v[0];
    assign m_timeout    = timeout_v[0];
    assign master_valid = valid_v[0];
    assign master_data  = data_v[0];
    assign s_full       = full_v[1];
    assign s_count      = count_v[1];
    assign s_timeout    = timeout_v[1];
    assign slave_valid  = valid_v[1];
    assign slave_data   = data_v[1];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
        logic [CW-1:0]     count_q, count_d;
        logic [TW-1:0]     stall_q, stall_d;
        logic              timeout_q, timeout_d;
        logic              do_push, do_pop, stalled;

        always_comb begin
            do_push   = push_v[c] && (count_q != CW'(DEPTH));
            do_pop    = (count_q != '0) && ready_v[c];
            stalled   = (count_q != '0) && !ready_v[c];
            count_d   = count_q;
            stall_d   = '0;
            timeout_d = timeout_q && !clr_err;
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CW'(1);
            end
            // Counter parks at TIMEOUT-1; a further stalled edge sets the flag.
            if (stalled) begin
                stall_d = stall_q;
                if (stall_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                end else begin
                    stall_d = stall_q + TW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                count_q   <= '0;
                stall_q   <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q   <= count_d;
                stall_q   <= stall_d;
                timeout_q <= timeout_d;
            end
        end

        always_ff @(posedge clk) begin
            if (do_push) mem_q[wr_ptr_q] <= push_data_v[c];
        end

        assign valid_v[c]   = (count_q != '0);
        assign full_v[c]    = (count_q == CW'(DEPTH));
        assign count_v[c]   = count_q;
        assign timeout_v[c] = timeout_q;
        assign data_v[c]    = valid_v[c] ? mem_q[rd_ptr_q] : '0;
    end

endmodule
